// File: rtl/tempo_pkg.sv
// Shared tempo encoding for the beat generator: signed rate codes and the
// helper that turns a rate into a beat period.
package tempo_pkg;

    typedef logic signed [2:0] rate_t;

    localparam rate_t RATE_X4_SLOW = 3'sd2;
    localparam rate_t RATE_X2_SLOW = 3'sd1;
    localparam rate_t RATE_NORM    = 3'sd0;
    localparam rate_t RATE_X2_FAST = -3'sd1;
    localparam rate_t RATE_X4_FAST = -3'sd2;

    // Positive rates slow the tempo (longer period), negative rates speed it up.
    // Right shifts truncate, so odd bases lose the remainder.
    function automatic int unsigned period_cycles(input int unsigned base, input rate_t r);
        case (r)
            RATE_X4_SLOW: return base << 2;
            RATE_X2_SLOW: return base << 1;
            RATE_X2_FAST: return base >> 1;
            RATE_X4_FAST: return base >> 2;
            default:      return base;
        endcase
    endfunction

endpackage

// File: rtl/tempo_beat_gen_if.sv
// Signal bundle between master_fsm/sequencer and tempo_beat_gen.
interface tempo_beat_gen_if;

    // All signals are levels sampled on the rising clock; there is no
    // valid/ready handshake. beat and rate_err are single-cycle strobes.
    logic              enable;
    logic              shift_left_1;
    logic              shift_left_2;
    logic              shift_right_1;
    logic              shift_right_2;
    logic              beat;
    tempo_pkg::rate_t  rate;
    logic              rate_err;

    modport master (
        output enable,
        output shift_left_1,
        output shift_left_2,
        output shift_right_1,
        output shift_right_2,
        input  beat,
        input  rate,
        input  rate_err
    );

    modport slave (
        input  enable,
        input  shift_left_1,
        input  shift_left_2,
        input  shift_right_1,
        input  shift_right_2,
        output beat,
        output rate,
        output rate_err
    );

endinterface

// File: rtl/beat_counter.sv
// Beat counter: counts enabled cycles against the period selected by rate and
// emits a one-cycle beat on each wrap; restart_i clears the count silently.
module beat_counter
    import tempo_pkg::*;
#(
    parameter int BASE_PERIOD = 1000,
    parameter int CNT_W       = 14
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable_i,
    input  logic  restart_i,
    input  rate_t rate_i,
    output logic  beat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] last_cnt;
    logic             beat_q;
    logic             beat_d;

    assign period   = CNT_W'(period_cycles(BASE_PERIOD, rate_i));
    assign last_cnt = period - CNT_W'(1);

    // ">=" rather than "==" so a count stranded above a freshly shrunk period
    // wraps at once instead of running all the way round the counter.
    always_comb begin
        cnt_d  = cnt_q;
        beat_d = 1'b0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q >= last_cnt) begin
                cnt_d  = '0;
                beat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            beat_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;

endmodule

// File: rtl/tempo_beat_gen.sv
// Tempo beat generator: decodes master_fsm shift levels into a signed rate and
// drives beat_counter. Optional macro TEMPO_SYNC_RESTART_EN restarts the count on rate change.
module tempo_beat_gen
    import tempo_pkg::*;
#(
    parameter int BASE_PERIOD = 1000,
    parameter int CNT_W       = 14
) (
    input  logic             clock,
    input  logic             reset,
    tempo_beat_gen_if.slave  bus
);

    logic [3:0] shift_vec;
    rate_t      rate_q;
    rate_t      rate_d;
    logic       rate_err_q;
    logic       rate_err_d;
    logic       restart;
    logic       beat;

    assign shift_vec = {bus.shift_left_2, bus.shift_left_1,
                        bus.shift_right_1, bus.shift_right_2};

    // Any multi-hot pattern is rejected outright: rate keeps its old value.
    always_comb begin
        rate_d     = rate_q;
        rate_err_d = 1'b0;
        case (shift_vec)
            4'b0000: rate_d = RATE_NORM;
            4'b1000: rate_d = RATE_X4_SLOW;
            4'b0100: rate_d = RATE_X2_SLOW;
            4'b0010: rate_d = RATE_X2_FAST;
            4'b0001: rate_d = RATE_X4_FAST;
            default: rate_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_q     <= RATE_NORM;
            rate_err_q <= 1'b0;
        end else begin
            rate_q     <= rate_d;
            rate_err_q <= rate_err_d;
        end
    end

`ifdef TEMPO_SYNC_RESTART_EN
    rate_t rate_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_prev_q <= RATE_NORM;
        end else begin
            rate_prev_q <= rate_q;
        end
    end

    // High for exactly the cycle after rate_q takes a new value.
    assign restart = (rate_q != rate_prev_q);
`else
    assign restart = 1'b0;
`endif

    beat_counter #(
        .BASE_PERIOD (BASE_PERIOD),
        .CNT_W       (CNT_W)
    ) u_beat_counter (
        .clock     (clock),
        .reset     (reset),
        .enable_i  (bus.enable),
        .restart_i (restart),
        .rate_i    (rate_q),
        .beat_o    (beat)
    );

    assign bus.beat     = beat;
    assign bus.rate     = rate_q;
    assign bus.rate_err = rate_err_q;

endmodule
